nes_joypad: RTL and testbench

//  Standard NES controller model: the responder end of the $4016/$4017 joypad interface driven by the APU.

---
 rtl/nes_pkg.sv | 18 +
 rtl/nes_joypad_debounce.sv | 42 ++++
 rtl/nes_joypad.sv | 55 +++++
 tb/tb_nes_joypad.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared NES joypad definitions: button bit positions in controller report order.
// Pure declarations; no logic, no latency, no flow control.
package nes_pkg;

  localparam int JOY_BITS = 8;

  typedef enum logic [2:0] {
    BTN_A      = 3'd0,
    BTN_B      = 3'd1,
    BTN_SELECT = 3'd2,
    BTN_START  = 3'd3,
    BTN_UP     = 3'd4,
    BTN_DOWN   = 3'd5,
    BTN_LEFT   = 3'd6,
    BTN_RIGHT  = 3'd7
  } btn_e;

endpackage

// File: rtl/nes_joypad_debounce.sv
// One-bit synchroniser + debouncer; SYNC_STAGES + DEBOUNCE_CYC cycles from raw edge to state change.
// No backpressure: free-running, state follows a raw level only after it has been stable long enough.
module joypad_debounce #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 50000,
  parameter bit INVERT       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic state_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   level;
  logic [CNT_W-1:0]       cnt;

  // Inversion sits after the synchroniser so reset-cleared flops read as "pressed" when active-low.
  assign level = sync[SYNC_STAGES-1] ^ INVERT;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      cnt     <= '0;
      state_o <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw_i};
      if (level == state_o) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        state_o <= ~state_o;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/nes_joypad.sv
// NES controller responder: debounced buttons latched while strobe is high, shifted out once per read rising edge.
// data_o is registered; one shift per read pulse regardless of pulse length, no backpressure to the APU.
module nes_joypad
  import nes_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 50000,
  parameter bit BTN_ACT_LOW  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                strobe_i,
  input  logic                read_i,
  input  logic [JOY_BITS-1:0] buttons_i,
  output logic                data_o,
  output logic [JOY_BITS-1:0] btn_o
);

  logic                read_q;
  logic                rd_edge;
  logic [JOY_BITS-1:0] shift_reg;

  for (genvar i = 0; i < JOY_BITS; i++) begin : g_btn
    joypad_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .INVERT      (BTN_ACT_LOW)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (buttons_i[i]),
      .state_o(btn_o[i])
    );
  end

  assign rd_edge = read_i & ~read_q;

  // Strobe overrides any read edge; ones fill from the top so reads past the eighth return 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_q    <= 1'b0;
      shift_reg <= '0;
    end else begin
      read_q <= read_i;
      if (strobe_i) begin
        shift_reg <= btn_o;
      end else if (rd_edge) begin
        shift_reg <= {1'b1, shift_reg[JOY_BITS-1:1]};
      end
    end
  end

  assign data_o = shift_reg[BTN_A];

endmodule

// File: tb/tb_nes_joypad.sv
// Directed bench for nes_joypad with DEBOUNCE_CYC=4, SYNC_STAGES=2: vector table plus hand sequences.
module tb_nes_joypad;
  import nes_pkg::*;

  logic       clk;
  logic       rst;
  logic       strobe_i;
  logic       read_i;
  logic [7:0] buttons_i;
  logic       data_o;
  logic [7:0] btn_o;

  int checks = 0;
  int errors = 0;

  nes_joypad #(
    .SYNC_STAGES (2),
    .DEBOUNCE_CYC(4),
    .BTN_ACT_LOW (1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .strobe_i (strobe_i),
    .read_i   (read_i),
    .buttons_i(buttons_i),
    .data_o   (data_o),
    .btn_o    (btn_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each vector: check outputs presented now (what the APU samples at the next edge), then apply inputs.
  typedef struct {
    logic       strobe;
    logic       read;
    logic [7:0] buttons;
    logic       chk_data;
    logic       exp_data;
    logic       chk_btn;
    logic [7:0] exp_btn;
    string      name;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] cur_btn;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic s, input logic r, input logic cd, input logic ed, input string nm);
    vec_t v;
    v.strobe   = s;
    v.read     = r;
    v.buttons  = cur_btn;
    v.chk_data = cd;
    v.exp_data = ed;
    v.chk_btn  = 1'b0;
    v.exp_btn  = 8'h00;
    v.name     = nm;
    vecs.push_back(v);
  endtask

  // Hold new buttons for n vectors; the last one checks the debounced state after n-1 cycles.
  task automatic add_idle(input int n, input logic [7:0] b);
    cur_btn = b;
    for (int k = 0; k < n; k++) add(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    vecs[vecs.size()-1].chk_btn = 1'b1;
    vecs[vecs.size()-1].exp_btn = b;
    vecs[vecs.size()-1].name    = "btn_settle";
  endtask

  initial begin
    logic [9:0] seq2;
    vec_t       v;

    rst       = 1'b1;
    strobe_i  = 1'b0;
    read_i    = 1'b0;
    buttons_i = 8'hFF;

    // Reset with all buttons held
    repeat (3) step();
    rst = 1'b0;
    chk("rst_data", {7'b0, data_o}, 8'h00);
    chk("rst_btn", btn_o, 8'h00);
    repeat (5) step();
    chk("rst_btn_early", btn_o, 8'h00);
    step();
    chk("rst_btn_settle", btn_o, 8'hFF);

    // Latch 0x09 and read ten times
    add_idle(9, 8'h09);
    add(1'b1, 1'b0, 1'b0, 1'b0, "latch09");
    seq2 = 10'b11_0000_1001;
    for (int k = 0; k < 10; k++) begin
      add(1'b0, 1'b1, 1'b1, seq2[k], $sformatf("read%0d", k + 1));
      add(1'b0, 1'b0, 1'b0, 1'b0, "gap");
    end

    // Held read: one shift only
    add_idle(9, 8'h02);
    add(1'b1, 1'b0, 1'b0, 1'b0, "latch02");
    add(1'b0, 1'b1, 1'b1, 1'b0, "held_a");
    for (int k = 0; k < 4; k++) add(1'b0, 1'b1, 1'b1, 1'b1, "held_const");
    add(1'b0, 1'b0, 1'b1, 1'b1, "held_release");
    add(1'b0, 1'b1, 1'b1, 1'b1, "held_next_b");
    add(1'b0, 1'b0, 1'b0, 1'b0, "gap");
    add(1'b0, 1'b1, 1'b1, 1'b0, "held_next_sel");
    add(1'b0, 1'b0, 1'b0, 1'b0, "gap");

    // Reads under strobe, read held across strobe fall
    add_idle(9, 8'h01);
    add(1'b1, 1'b0, 1'b0, 1'b0, "strb");
    add(1'b1, 1'b1, 1'b1, 1'b1, "strb_rd1");
    add(1'b1, 1'b0, 1'b1, 1'b1, "strb_gap");
    add(1'b1, 1'b1, 1'b1, 1'b1, "strb_rd2");
    add(1'b0, 1'b1, 1'b1, 1'b1, "strb_fall_rd_high");
    add(1'b0, 1'b0, 1'b1, 1'b1, "after_fall");
    add(1'b0, 1'b1, 1'b1, 1'b1, "post_a");
    add(1'b0, 1'b0, 1'b0, 1'b0, "gap");
    add(1'b0, 1'b1, 1'b1, 1'b0, "post_b");
    add(1'b0, 1'b0, 1'b0, 1'b0, "gap");

    // Buttons change between latches, then read edge coincides with strobe rise
    add_idle(9, 8'h00);
    add(1'b1, 1'b0, 1'b0, 1'b0, "latch00");
    add(1'b0, 1'b0, 1'b1, 1'b0, "latched00");
    add_idle(9, 8'h05);
    add(1'b0, 1'b0, 1'b1, 1'b0, "no_reload");
    add(1'b1, 1'b1, 1'b0, 1'b0, "coincide");
    add(1'b0, 1'b0, 1'b1, 1'b1, "coincide_load");
    add(1'b0, 1'b1, 1'b1, 1'b1, "co_a");
    add(1'b0, 1'b0, 1'b0, 1'b0, "gap");
    add(1'b0, 1'b1, 1'b1, 1'b0, "co_b");
    add(1'b0, 1'b0, 1'b0, 1'b0, "gap");
    add(1'b0, 1'b1, 1'b1, 1'b1, "co_sel");
    add(1'b0, 1'b0, 1'b0, 1'b0, "gap");

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.chk_data) chk(v.name, {7'b0, data_o}, {7'b0, v.exp_data});
      if (v.chk_btn) chk(v.name, btn_o, v.exp_btn);
      strobe_i  = v.strobe;
      read_i    = v.read;
      buttons_i = v.buttons;
      step();
    end

    // Bounce on button A
    buttons_i = 8'h04;
    repeat (8) step();
    chk("bounce_start", btn_o, 8'h04);
    for (int k = 0; k < 10; k++) begin
      buttons_i[0] = (k % 2 == 0);
      repeat (2) begin
        step();
        chk("bounce_chatter", {7'b0, btn_o[0]}, 8'h00);
      end
    end
    buttons_i[0] = 1'b1;
    repeat (5) step();
    chk("bounce_early", btn_o, 8'h04);
    step();
    chk("bounce_settle", btn_o, 8'h05);

    // Reset asserted mid-read discards everything
    strobe_i = 1'b1;
    step();
    strobe_i = 1'b0;
    step();
    chk("pre_rst_data", {7'b0, data_o}, 8'h01);
    read_i = 1'b1;
    rst    = 1'b1;
    step();
    chk("midrd_rst_data", {7'b0, data_o}, 8'h00);
    chk("midrd_rst_btn", btn_o, 8'h00);
    rst    = 1'b0;
    read_i = 1'b0;
    step();
    chk("post_rst_data", {7'b0, data_o}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
